memwb_stage: RTL and testbench

Parametrised MEM/WB pipeline register with valid tracking, stall/flush control, integrated write-back select and a saturating retired-instruction counter. It sits between the data-memory stage and the register file. It replaces the fixed-width MEM/WB latch so that hazard control and write-back muxing live in one place. Its outputs drive the register-file write port and the forwarding unit directly.

---
 rtl/memwb_stage.sv | 177 +++++++++++++++++
 tb/tb_memwb_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage.sv
// memwb_stage
//   MEM/WB pipeline register placed between the data-memory stage and the
//   register file. It tracks whether the held entry is a real instruction,
//   applies stall/flush control, selects the write-back data and counts
//   retired instructions with a saturating counter.
//
// Parameters
//   DATA_W  width of memory-read and ALU result data
//   REG_W   destination register index width
//   WB_W    write-back control width (bit 1 = RegWrite, bit 0 = MemtoReg,
//           any higher bits are carried through untouched)
//   CNT_W   retired-instruction counter width (2 or more)
//
// Ports
//   clock         rising-edge clock for all state
//   reset         asynchronous active-high reset
//   stall         hold every register this cycle
//   flush         load a bubble instead of the incoming entry (beats stall)
//   valid_in      incoming MEM entry is a real instruction
//   WB            write-back control from MEM
//   Memout        data-memory read data
//   ALUOut        ALU result passed through MEM
//   RegRD         destination register index
//   count_clear   synchronous clear of the retired counter
//   valid_out     registered entry is valid
//   WBreg         registered write-back control
//   Memreg        registered memory data
//   ALUreg        registered ALU result
//   RegRDreg      registered destination index
//   RegWrite_out  register-file write enable (from registers only)
//   WriteData     register-file write data (from registers only)
//   retired       saturating count of valid entries that left the stage
module memwb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [WB_W-1:0]   WB,
  input  logic [DATA_W-1:0] Memout,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [REG_W-1:0]  RegRD,
  input  logic              count_clear,
  output logic              valid_out,
  output logic [WB_W-1:0]   WBreg,
  output logic [DATA_W-1:0] Memreg,
  output logic [DATA_W-1:0] ALUreg,
  output logic [REG_W-1:0]  RegRDreg,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] WriteData,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WB_W-1:0]   WB_ZERO  = {WB_W{1'b0}};
  localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};
  localparam logic [REG_W-1:0]  REG_ZERO = {REG_W{1'b0}};

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      sat_inc = value;
    end else begin
      sat_inc = value + CNT_ONE;
    end
  endfunction

  // Stage registers
  logic              valid_r;
  logic [WB_W-1:0]   wb_r;
  logic [DATA_W-1:0] mem_r;
  logic [DATA_W-1:0] alu_r;
  logic [REG_W-1:0]  rd_r;
  logic [CNT_W-1:0]  retired_r;

  // Next-state values
  logic              valid_nxt_s;
  logic [WB_W-1:0]   wb_nxt_s;
  logic [DATA_W-1:0] mem_nxt_s;
  logic [DATA_W-1:0] alu_nxt_s;
  logic [REG_W-1:0]  rd_nxt_s;
  logic [CNT_W-1:0]  retired_nxt_s;
  logic              retire_s;

  // The held entry completes whenever the stage advances; a flush advances
  // the stage too, it only discards the incoming entry.
  assign retire_s = valid_r & (~stall | flush);

  // Stage next-state: flush beats stall, stall beats a normal load.
  always_comb begin
    valid_nxt_s = valid_r;
    wb_nxt_s    = wb_r;
    mem_nxt_s   = mem_r;
    alu_nxt_s   = alu_r;
    rd_nxt_s    = rd_r;
    if (flush) begin
      // Data fields are don't-care in a bubble; loading them keeps the
      // datapath enables identical to a normal load.
      valid_nxt_s = 1'b0;
      wb_nxt_s    = WB_ZERO;
      mem_nxt_s   = Memout;
      alu_nxt_s   = ALUOut;
      rd_nxt_s    = RegRD;
    end else if (stall) begin
      valid_nxt_s = valid_r;
      wb_nxt_s    = wb_r;
      mem_nxt_s   = mem_r;
      alu_nxt_s   = alu_r;
      rd_nxt_s    = rd_r;
    end else begin
      // An invalid incoming entry must never carry write-back control.
      valid_nxt_s = valid_in;
      wb_nxt_s    = valid_in ? WB : WB_ZERO;
      mem_nxt_s   = Memout;
      alu_nxt_s   = ALUOut;
      rd_nxt_s    = RegRD;
    end
  end

  // Counter next-state: clear wins over a simultaneous retire.
  always_comb begin
    retired_nxt_s = retired_r;
    if (count_clear) begin
      retired_nxt_s = CNT_ZERO;
    end else if (retire_s) begin
      retired_nxt_s = sat_inc(retired_r);
    end else begin
      retired_nxt_s = retired_r;
    end
  end

  // Stage register bank with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      wb_r    <= WB_ZERO;
      mem_r   <= DAT_ZERO;
      alu_r   <= DAT_ZERO;
      rd_r    <= REG_ZERO;
    end else begin
      valid_r <= valid_nxt_s;
      wb_r    <= wb_nxt_s;
      mem_r   <= mem_nxt_s;
      alu_r   <= alu_nxt_s;
      rd_r    <= rd_nxt_s;
    end
  end

  // Retired-instruction counter with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_r <= CNT_ZERO;
    end else begin
      retired_r <= retired_nxt_s;
    end
  end

  assign valid_out = valid_r;
  assign WBreg     = wb_r;
  assign Memreg    = mem_r;
  assign ALUreg    = alu_r;
  assign RegRDreg  = rd_r;
  assign retired   = retired_r;

  // Register 0 is hard-wired, so a write to it is dropped here rather than
  // relying on the register file.
  assign RegWrite_out = valid_r & wb_r[1] & (rd_r != REG_ZERO);
  assign WriteData    = wb_r[0] ? mem_r : alu_r;

endmodule

// File: tb/tb_memwb_stage.sv
// Directed testbench for memwb_stage. Two instances share the stimulus: one
// with the default 32-bit counter and one with a 4-bit counter so the
// saturation boundary can be reached quickly.
module tb_memwb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [1:0]  WB;
  logic [31:0] Memout;
  logic [31:0] ALUOut;
  logic [4:0]  RegRD;
  logic        count_clear;

  logic        valid_out;
  logic [1:0]  WBreg;
  logic [31:0] Memreg;
  logic [31:0] ALUreg;
  logic [4:0]  RegRDreg;
  logic        RegWrite_out;
  logic [31:0] WriteData;
  logic [31:0] retired;

  logic        valid_out4;
  logic [1:0]  WBreg4;
  logic [31:0] Memreg4;
  logic [31:0] ALUreg4;
  logic [4:0]  RegRDreg4;
  logic        RegWrite_out4;
  logic [31:0] WriteData4;
  logic [3:0]  retired4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  memwb_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .WB(WB), .Memout(Memout), .ALUOut(ALUOut),
    .RegRD(RegRD), .count_clear(count_clear),
    .valid_out(valid_out), .WBreg(WBreg), .Memreg(Memreg), .ALUreg(ALUreg),
    .RegRDreg(RegRDreg), .RegWrite_out(RegWrite_out), .WriteData(WriteData),
    .retired(retired)
  );

  memwb_stage #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .WB(WB), .Memout(Memout), .ALUOut(ALUOut),
    .RegRD(RegRD), .count_clear(count_clear),
    .valid_out(valid_out4), .WBreg(WBreg4), .Memreg(Memreg4), .ALUreg(ALUreg4),
    .RegRDreg(RegRDreg4), .RegWrite_out(RegWrite_out4), .WriteData(WriteData4),
    .retired(retired4)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd);
    valid_in = v;
    WB       = wb;
    Memout   = mem;
    ALUOut   = alu;
    RegRD    = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; count_clear = 1'b0;
    drive(1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
    step();
    step();
    n_checks++;
    if ({valid_out, WBreg, Memreg, ALUreg, RegRDreg, RegWrite_out, WriteData, retired} !== 107'd0)
      $display("FAIL reset_outputs: got v=%b wb=%b mem=%h alu=%h rd=%0d we=%b wd=%h ret=%0d, want all 0",
               valid_out, WBreg, Memreg, ALUreg, RegRDreg, RegWrite_out, WriteData, retired);
    else n_pass++;
    n_checks++;
    if (retired4 !== 4'd0) $display("FAIL reset_retired4: got %0d want 0", retired4);
    else n_pass++;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h00000010, 5'd5);
    step();
    n_checks++;
    if ({valid_out, RegWrite_out, RegRDreg, WriteData} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL load_mem: got v=%b we=%b rd=%0d wd=%h, want 1 1 5 deadbeef",
               valid_out, RegWrite_out, RegRDreg, WriteData);
    else n_pass++;
    n_checks++;
    if (retired !== 32'd0) $display("FAIL load_first_retired: got %0d want 0", retired);
    else n_pass++;
    drive(1'b1, 2'b10, 32'hDEADBEEF, 32'h00000010, 5'd5);
    step();
    n_checks++;
    if ({RegWrite_out, WriteData, retired} !== {1'b1, 32'h00000010, 32'd1})
      $display("FAIL load_alu: got we=%b wd=%h ret=%0d, want 1 00000010 1",
               RegWrite_out, WriteData, retired);
    else n_pass++;
  endtask

  task automatic test_reg0();
    drive(1'b1, 2'b10, 32'h12345678, 32'h87654321, 5'd0);
    step();
    n_checks++;
    if ({valid_out, RegWrite_out, retired} !== {1'b1, 1'b0, 32'd2})
      $display("FAIL reg0_suppress: got v=%b we=%b ret=%0d, want 1 0 2",
               valid_out, RegWrite_out, retired);
    else n_pass++;
    // Invalid incoming entry with write-back bits set must become a bubble.
    drive(1'b0, 2'b11, 32'h0, 32'h0, 5'd6);
    step();
    n_checks++;
    if ({valid_out, WBreg, RegWrite_out, retired} !== {1'b0, 2'b00, 1'b0, 32'd3})
      $display("FAIL invalid_bubble: got v=%b wb=%b we=%b ret=%0d, want 0 00 0 3",
               valid_out, WBreg, RegWrite_out, retired);
    else n_pass++;
    step();
    n_checks++;
    if (retired !== 32'd3) $display("FAIL bubble_no_retire: got %0d want 3", retired);
    else n_pass++;
  endtask

  task automatic test_stall_hold();
    drive(1'b1, 2'b11, 32'hA1A1A1A1, 32'h00000002, 5'd7);
    step();
    stall = 1'b1;
    drive(1'b1, 2'b10, 32'hB2B2B2B2, 32'h00000033, 5'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({valid_out, WBreg, Memreg, RegRDreg, RegWrite_out, WriteData, retired} !==
          {1'b1, 2'b11, 32'hA1A1A1A1, 5'd7, 1'b1, 32'hA1A1A1A1, 32'd3})
        $display("FAIL stall_hold[%0d]: got v=%b wb=%b mem=%h rd=%0d we=%b wd=%h ret=%0d, want 1 11 a1a1a1a1 7 1 a1a1a1a1 3",
                 i, valid_out, WBreg, Memreg, RegRDreg, RegWrite_out, WriteData, retired);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_checks++;
    if ({Memreg, RegRDreg, WriteData, retired} !== {32'hB2B2B2B2, 5'd9, 32'h00000033, 32'd4})
      $display("FAIL stall_release: got mem=%h rd=%0d wd=%h ret=%0d, want b2b2b2b2 9 00000033 4",
               Memreg, RegRDreg, WriteData, retired);
    else n_pass++;
  endtask

  task automatic test_flush_over_stall();
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 2'b11, 32'hC3C3C3C3, 32'h00000044, 5'd10);
    step();
    n_checks++;
    if ({valid_out, WBreg, RegWrite_out, retired} !== {1'b0, 2'b00, 1'b0, 32'd5})
      $display("FAIL flush_over_stall: got v=%b wb=%b we=%b ret=%0d, want 0 00 0 5",
               valid_out, WBreg, RegWrite_out, retired);
    else n_pass++;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    step();
    n_checks++;
    if (retired !== 32'd5) $display("FAIL flush_bubble_no_retire: got %0d want 5", retired);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b11, 32'h11111111, 32'hEEEEEEEE, 5'd1);
    step();
    n_checks++;
    if ({WriteData, RegWrite_out, retired} !== {32'h11111111, 1'b1, 32'd5})
      $display("FAIL b2b_0: got wd=%h we=%b ret=%0d, want 11111111 1 5", WriteData, RegWrite_out, retired);
    else n_pass++;
    drive(1'b1, 2'b10, 32'hEEEEEEEE, 32'h22222222, 5'd2);
    step();
    n_checks++;
    if ({WriteData, RegRDreg, retired} !== {32'h22222222, 5'd2, 32'd6})
      $display("FAIL b2b_1: got wd=%h rd=%0d ret=%0d, want 22222222 2 6", WriteData, RegRDreg, retired);
    else n_pass++;
    drive(1'b1, 2'b11, 32'h33333333, 32'hEEEEEEEE, 5'd3);
    step();
    n_checks++;
    if ({WriteData, RegRDreg, retired} !== {32'h33333333, 5'd3, 32'd7})
      $display("FAIL b2b_2: got wd=%h rd=%0d ret=%0d, want 33333333 3 7", WriteData, RegRDreg, retired);
    else n_pass++;
  endtask

  task automatic test_counter_sat();
    // A retire event is live here (valid entry, no stall); clear must win.
    count_clear = 1'b1;
    drive(1'b1, 2'b11, 32'h44444444, 32'h0, 5'd4);
    step();
    n_checks++;
    if ({retired, retired4} !== {32'd0, 4'd0})
      $display("FAIL clear_vs_retire: got %0d/%0d want 0/0", retired, retired4);
    else n_pass++;
    count_clear = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        n_checks++;
        if (retired4 !== 4'hE) $display("FAIL sat_14: got %h want e", retired4);
        else n_pass++;
      end
      if (i == 15) begin
        n_checks++;
        if (retired4 !== 4'hF) $display("FAIL sat_15: got %h want f", retired4);
        else n_pass++;
      end
    end
    n_checks++;
    if ({retired4, retired} !== {4'hF, 32'd20})
      $display("FAIL sat_20: got %h/%0d want f/20", retired4, retired);
    else n_pass++;
    count_clear = 1'b1;
    step();
    n_checks++;
    if ({retired4, retired} !== {4'h0, 32'd0})
      $display("FAIL sat_clear: got %h/%0d want 0/0", retired4, retired);
    else n_pass++;
    count_clear = 1'b0;
    step();
    n_checks++;
    if ({retired4, retired} !== {4'h1, 32'd1})
      $display("FAIL after_clear: got %h/%0d want 1/1", retired4, retired);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b11, 32'h55555555, 32'h66666666, 5'd8);
    step();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({valid_out, WBreg, Memreg, ALUreg, RegRDreg, RegWrite_out, WriteData, retired, retired4} !== 111'd0)
      $display("FAIL async_reset: got v=%b wb=%b mem=%h alu=%h rd=%0d we=%b wd=%h ret=%0d ret4=%0d, want all 0",
               valid_out, WBreg, Memreg, ALUreg, RegRDreg, RegWrite_out, WriteData, retired, retired4);
    else n_pass++;
    step();
    n_checks++;
    if ({valid_out, RegWrite_out, retired} !== {1'b0, 1'b0, 32'd0})
      $display("FAIL reset_held: got v=%b we=%b ret=%0d want 0 0 0", valid_out, RegWrite_out, retired);
    else n_pass++;
    reset = 1'b0;
    drive(1'b1, 2'b11, 32'h77777777, 32'h0, 5'd3);
    step();
    n_checks++;
    if ({valid_out, RegWrite_out, WriteData, retired} !== {1'b1, 1'b1, 32'h77777777, 32'd0})
      $display("FAIL post_reset_load: got v=%b we=%b wd=%h ret=%0d want 1 1 77777777 0",
               valid_out, RegWrite_out, WriteData, retired);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_reg0();
    test_stall_hold();
    test_flush_over_stall();
    test_back_to_back();
    test_counter_sat();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
